// File: rtl/alu_pkg.sv
// Shared constants and types for the 6502-style ALU and its BCD nibble slice.
package alu_pkg;

  localparam int         DATA_W        = 8;
  localparam logic [3:0] BCD_ADJ       = 4'd6;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_6502_if.sv
// Operand/control/result bundle between the CPU datapath and alu_6502.
interface alu_6502_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] INA;
  logic [DATA_W-1:0] INB;
  logic              CIN;
  logic              BCD;
  logic              SBC;
  logic [DATA_W-1:0] OUT;
  logic              N;
  logic              Z;
  logic              C;
  logic              V;

  modport master (
    output INA, INB, CIN, BCD, SBC,
    input  OUT, N, Z, C, V
  );

  modport slave (
    input  INA, INB, CIN, BCD, SBC,
    output OUT, N, Z, C, V
  );

endinterface

// File: rtl/alu_bcd_nibble.sv
// One decimal digit of ADC/SBC: 4-bit add or subtract with decimal adjust.
// ci/co are carries for add and "no borrow" flags for subtract, as on the 6502.
module alu_bcd_nibble
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  input  logic       sub,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] raw;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    raw = '0;
    s   = '0;
    co  = 1'b0;
    if (sub) begin
      // Bit 4 of the 5-bit difference is the borrow out of this digit.
      raw = {1'b0, a} - {1'b0, b} - {4'd0, ~ci};
      co  = ~raw[4];
      s   = raw[4] ? raw[3:0] - BCD_ADJ : raw[3:0];
    end else begin
      raw = {1'b0, a} + {1'b0, b} + {4'd0, ci};
      co  = (raw > {1'b0, BCD_MAX_DIGIT});
      s   = co ? raw[3:0] + BCD_ADJ : raw[3:0];
    end
  end

endmodule

// File: rtl/alu_6502.sv
// Registered 8-bit ADC/SBC unit with N/Z/C/V flags; one cycle of latency.
// Decimal mode exists only when ALU_BCD_EN is defined; otherwise BCD is ignored.
module alu_6502
  import alu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  alu_6502_if.slave  bus
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   bin_sum;
  logic              bin_v;
  logic [DATA_W-1:0] res_d;
  logic              carry_d;
  flags_t            flags_d;
  logic [DATA_W-1:0] res_q;
  flags_t            flags_q;

  always_comb begin
    b_eff   = bus.SBC ? ~bus.INB : bus.INB;
    bin_sum = {1'b0, bus.INA} + {1'b0, b_eff} + {{DATA_W{1'b0}}, bus.CIN};
    bin_v   = (bus.INA[DATA_W-1] == b_eff[DATA_W-1]) &&
              (bin_sum[DATA_W-1] != bus.INA[DATA_W-1]);
  end

`ifdef ALU_BCD_EN
  logic [3:0] lo_s;
  logic [3:0] hi_s;
  logic       lo_co;
  logic       hi_co;

  // Digits take the raw operand; the slice handles subtraction itself.
  alu_bcd_nibble u_lo (
    .a   (bus.INA[3:0]),
    .b   (bus.INB[3:0]),
    .ci  (bus.CIN),
    .sub (bus.SBC),
    .s   (lo_s),
    .co  (lo_co)
  );

  alu_bcd_nibble u_hi (
    .a   (bus.INA[7:4]),
    .b   (bus.INB[7:4]),
    .ci  (lo_co),
    .sub (bus.SBC),
    .s   (hi_s),
    .co  (hi_co)
  );

  always_comb begin
    res_d   = bus.BCD ? {hi_s, lo_s} : bin_sum[DATA_W-1:0];
    carry_d = bus.BCD ? hi_co        : bin_sum[DATA_W];
  end
`else
  logic unused_bcd;

  assign unused_bcd = bus.BCD;
  assign res_d      = bin_sum[DATA_W-1:0];
  assign carry_d    = bin_sum[DATA_W];
`endif

  // V always comes from the binary sum, even in decimal mode.
  always_comb begin
    flags_d.n = res_d[DATA_W-1];
    flags_d.z = (res_d == '0);
    flags_d.c = carry_d;
    flags_d.v = bin_v;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign bus.OUT = res_q;
  assign bus.N   = flags_q.n;
  assign bus.Z   = flags_q.z;
  assign bus.C   = flags_q.c;
  assign bus.V   = flags_q.v;

endmodule

// File: tb/tb_alu_6502.sv
// Self-checking bench for alu_6502: directed vector table, reset/latency sequence,
// and random operands against a plain-arithmetic model (ALU_BCD_EN aware).
module tb_alu_6502;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        bcd;
    logic        sbc;
    logic [11:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  alu_6502_if bus ();

  alu_6502 u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] dut_state();
    return {bus.OUT, bus.N, bus.Z, bus.C, bus.V};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got out=%h nzcv=%b, expected out=%h nzcv=%b",
               name, act[11:4], act[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic bcd, input logic sbc, input logic [7:0] out,
                         input logic [3:0] nzcv);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.bcd = bcd; v.sbc = sbc;
    v.exp = {out, nzcv};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic bcd, input logic sbc);
    bus.INA = a; bus.INB = b; bus.CIN = cin; bus.BCD = bcd; bus.SBC = sbc;
  endtask

  // Drive on the falling edge, sample 1 ns after the capturing rising edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic bcd, input logic sbc);
    @(negedge clk);
    drive(a, b, cin, bcd, sbc);
    @(posedge clk);
    #1;
  endtask

  // Reference: 6502 ADC/SBC rules computed with integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic bcd, input logic sbc);
    int ai, bi, bb, sum, lo, hi, lc;
    logic [7:0] out;
    logic n, z, c, v;
    ai  = int'(a);
    bi  = int'(b);
    bb  = sbc ? 255 - bi : bi;
    sum = ai + bb + int'(cin);
    out = 8'(sum);
    c   = (sum > 255);
    v   = ((ai >= 128) == (bb >= 128)) && ((sum % 256 >= 128) != (ai >= 128));
`ifdef ALU_BCD_EN
    if (bcd) begin
      if (!sbc) begin
        lo = ai % 16 + bi % 16 + int'(cin);
        lc = (lo > 9) ? 1 : 0;
        if (lc == 1) lo = lo + 6;
        hi = ai / 16 + bi / 16 + lc;
        c  = (hi > 9);
        if (c) hi = hi + 6;
      end else begin
        lo = ai % 16 - bi % 16 - (1 - int'(cin));
        lc = (lo < 0) ? 1 : 0;
        if (lc == 1) lo = lo - 6;
        hi = ai / 16 - bi / 16 - lc;
        c  = !(hi < 0);
        if (!c) hi = hi - 6;
      end
      out = 8'(((hi & 15) * 16) + (lo & 15));
    end
`else
    lo = bcd ? 0 : 0;
    hi = lo;
    lc = hi;
`endif
    n = out[7];
    z = (out == 8'h00);
    return {out, n, z, c, v};
  endfunction

  initial begin
    logic [11:0] held;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_state", dut_state(), 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: binary rows hold for both builds; decimal rows depend on the option.
    add_vec(8'h0D, 8'hD3, 1'b1, 1'b0, 1'b0, 8'hE1, 4'b1000);
    add_vec(8'hFE, 8'h06, 1'b1, 1'b0, 1'b0, 8'h05, 4'b0010);
    add_vec(8'h05, 8'h07, 1'b0, 1'b0, 1'b0, 8'h0C, 4'b0000);
    add_vec(8'h7F, 8'h02, 1'b1, 1'b0, 1'b0, 8'h82, 4'b1001);
    add_vec(8'hBE, 8'hBF, 1'b0, 1'b0, 1'b0, 8'h7D, 4'b0011);
    add_vec(8'hFB, 8'hF9, 1'b0, 1'b0, 1'b0, 8'hF4, 4'b1010);
    add_vec(8'h05, 8'h03, 1'b1, 1'b0, 1'b1, 8'h02, 4'b0010);
    add_vec(8'h05, 8'h06, 1'b1, 1'b0, 1'b1, 8'hFF, 4'b1000);
    add_vec(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0110);
`ifdef ALU_BCD_EN
    add_vec(8'h79, 8'h14, 1'b0, 1'b1, 1'b0, 8'h93, 4'b1001);
    add_vec(8'h44, 8'h29, 1'b1, 1'b1, 1'b1, 8'h15, 4'b0010);
    add_vec(8'h99, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0110);
    add_vec(8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 8'h99, 4'b1000);
`else
    add_vec(8'h79, 8'h14, 1'b0, 1'b1, 1'b0, 8'h8D, 4'b1001);
    add_vec(8'h44, 8'h29, 1'b1, 1'b1, 1'b1, 8'h1B, 4'b0010);
    add_vec(8'h99, 8'h01, 1'b0, 1'b1, 1'b0, 8'h9A, 4'b1000);
    add_vec(8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 8'hFF, 4'b1000);
`endif
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].bcd, vecs[i].sbc);
      check($sformatf("vec%0d_%h_%h", i, vecs[i].a, vecs[i].b), dut_state(), vecs[i].exp);
    end

    // Mid-cycle asynchronous reset, then first result only after the next rising edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", dut_state(), 12'h000);
    @(posedge clk);
    #1;
    check("reset_held", dut_state(), 12'h000);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h05, 8'hFD, 1'b0, 1'b0, 1'b0);
    #1;
    check("no_update_before_edge", dut_state(), 12'h000);
    @(posedge clk);
    #1;
    check("first_after_reset", dut_state(), {8'h02, 4'b0010});

    // Input changes between edges must not disturb the registered result.
    held = dut_state();
    @(negedge clk);
    drive(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0);
    #2;
    check("hold_between_edges", dut_state(), held);
    @(posedge clk);
    #1;
    check("after_change_edge", dut_state(), {8'hFF, 4'b1001});

    // Random operands, both modes, back to back.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, b;
      logic       cin, bcd, sbc;
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      bcd = 1'($urandom);
      sbc = 1'($urandom);
      apply(a, b, cin, bcd, sbc);
      check($sformatf("rand%0d_%h_%h_c%0d_d%0d_s%0d", i, a, b, cin, bcd, sbc),
            dut_state(), model(a, b, cin, bcd, sbc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_6502.md
Name: alu_6502

Overview:
- 8-bit 6502-style adder/subtractor with binary and packed-BCD (decimal) modes, and N/Z/C/V flag generation.
- Sits in the CPU datapath between the accumulator/operand buses and the status register; serves ADC and SBC.
- Result and flags are registered, giving one cycle of latency.

Parameters:
- none. Data width is fixed at 8 bits, held as a package constant.

Ports:
- CLK  in   1  rising-edge clock
- RST  in   1  asynchronous, active-high reset
- INA  in   8  operand A (accumulator)
- INB  in   8  operand B (memory operand)
- CIN  in   1  carry in (for SBC: 1 = no borrow)
- BCD  in   1  1 = decimal mode, 0 = binary mode
- SBC  in   1  1 = subtract, 0 = add
- OUT  out  8  registered result
- N    out  1  registered negative flag
- Z    out  1  registered zero flag
- C    out  1  registered carry flag
- V    out  1  registered overflow flag

Behaviour:
- Reset: RST high asynchronously forces OUT=0x00 and N=Z=C=V=0, and holds them while RST stays high.
- Latency: inputs are sampled on every rising CLK edge; OUT and flags reflect those inputs from that edge until the next edge. There is no handshake and no enable, so the block computes every cycle.
- Effective operand: B' = SBC ? ~INB : INB.
- Binary mode (BCD=0):
  - Computes the 9-bit sum S = INA + B' + CIN.
  - OUT = S[7:0] and C = S[8].
  - V = (INA[7] == B'[7]) && (S[7] != INA[7]).
  - N = OUT[7] and Z = (OUT == 0).
- Decimal add (BCD=1, SBC=0):
  - Low nibble: L = A[3:0] + B[3:0] + CIN. If L > 9, add 6 and carry into the high nibble.
  - High nibble: H = A[7:4] + B[7:4] + low carry. If H > 9, add 6 and set C=1; otherwise C=0.
- Decimal subtract (BCD=1, SBC=1):
  - Low nibble: L = A[3:0] - B[3:0] - (1 - CIN). On borrow, subtract 6 and propagate the borrow.
  - High nibble: computed the same way. On final borrow, subtract 6 and set C=0; otherwise C=1.
- Decimal flags:
  - N and Z are taken from the final BCD result.
  - V is taken from the binary computation of the same operands, using the rule above.
- Invalid BCD digits (A–F) need not produce valid BCD, but results must be deterministic. The nibble rules above are applied literally, with 4-bit wrap-around.
- Wrap-around:
  - 0xFF + 0x01 + 0 gives OUT=0x00, Z=1, C=1.
  - Decimal 0x99 + 0x01 + 0 gives OUT=0x00, C=1, Z=1.
- Input changes between edges have no effect on the outputs.

Optional Feature:
- Macro: ALU_BCD_EN.
- When defined: decimal mode works as described in Behaviour.
- When undefined: the BCD input is ignored, every operation uses the binary path, and no BCD adjust logic is synthesized.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W = 8
  - BCD_ADJ = 4'd6
  - BCD_MAX_DIGIT = 4'd9
  - a packed flags struct {N, Z, C, V}
- One sub-module, alu_bcd_nibble: a 4-bit add/subtract with decimal adjust and carry/borrow out. It is instantiated twice (low and high nibble) inside the ALU_BCD_EN guard.

Test Plan:
- Binary add:
  - 0x0D + 0xD3 + 1 -> OUT=0xE1, N1 Z0 C0 V0.
  - 0xFE + 0x06 + 1 -> 0x05, C1 V0.
  - 0x05 + 0x07 + 0 -> 0x0C, all flags 0.
- Overflow:
  - 0x7F + 0x02 + 1 -> 0x82, N1 C0 V1.
  - 0xBE + 0xBF + 0 -> 0x7D, N0 C1 V1.
  - 0xFB + 0xF9 + 0 -> 0xF4, N1 C1 V0.
- Binary subtract, SBC=1, CIN=1:
  - 0x05 - 0x03 -> 0x02, C1 N0.
  - 0x05 - 0x06 -> 0xFF, C0 N1 V0.
- Decimal add, BCD=1: 0x79 + 0x14 + 0 -> OUT=0x93, C0 N1 V1 Z0.
- Decimal subtract, BCD=1, SBC=1, CIN=1: 0x44 - 0x29 -> OUT=0x15, C1 N0 V0 Z0.
- Reset and latency:
  - Assert RST mid-run -> OUT=0x00 and flags 0 immediately, with no clock edge needed.
  - After deassert, apply 0x05 + 0xFD + 0 -> 0x02, C1, visible only after the next rising CLK.
